fft_frame_ctrl: RTL
===================

# fft_frame_ctrl

Frame sequencer in front of the 64-point FFT core. Accepts complex samples one per handshake, assembles a full frame into the FFT's parallel input arrays, fires the core's `start`, waits out its fixed compute latency, snapshots the parallel results and streams them out one bin per handshake. The input side may load the next frame while the previous frame's results are still draining.

## Interface
Parameters:
- `N`, 64: points per frame; power of two.
- `W`, 16: bits per real or imaginary part.
- `FFT_LATENCY`, 160: cycles from the `fft_start` cycle until `fft_out_*` are valid and stable; must be at least 1.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `abort`  in  1  synchronous flush of the whole block.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  input sample ready.
- `in_re`  in  W  input sample, real part.
- `in_im`  in  W  input sample, imaginary part.
- `fft_in_re`  out  N×W  registered frame driven to the core's `input_Re`.
- `fft_in_im`  out  N×W  registered frame driven to the core's `input_Im`.
- `fft_start`  out  1  one-cycle start pulse to the core.
- `fft_out_re`  in  N×W  core's `output_Re`.
- `fft_out_im`  in  N×W  core's `output_Im`.
- `out_valid`  out  1  output bin valid.
- `out_ready`  in  1  output bin ready.
- `out_re`  out  W  output bin, real part.
- `out_im`  out  W  output bin, imaginary part.
- `out_idx`  out  log2(N)  bin number of the current output word.
- `out_last`  out  1  high with bin N-1.
- `frames_out`  out  16  completed output frames; wraps at 0xFFFF→0.

## Operation
- Input FSM states: `S_LOAD`, `S_FIRE`, `S_WAIT`, `S_XFER`.
- **S_LOAD**
  - `in_ready`=1.
  - On `in_valid&&in_ready`: write the sample to `fft_in_*[wr_idx]`, then increment `wr_idx`.
  - Accepting the sample at `wr_idx`=N-1 moves the FSM to `S_FIRE` and sets `wr_idx` to 0.
- **S_FIRE**
  - `fft_start`=1 for exactly this one cycle.
  - Next state is `S_WAIT` with the latency counter loaded to `FFT_LATENCY`-1.
- **S_WAIT**
  - The counter decrements each cycle; at 0 the FSM moves to `S_XFER`.
- **S_XFER**
  - If `obuf_full`=0: copy all `fft_out_*` into the output buffer, set `obuf_full`, and go to `S_LOAD`.
  - If `obuf_full`=1: stay in `S_XFER`.
- `in_ready`=0 in every state except `S_LOAD`.
- `fft_in_*` change only on accepted writes in `S_LOAD`, so the frame stays stable through FIRE, WAIT and XFER.
- **Output side**
  - `out_valid`=`obuf_full`.
  - `out_re`, `out_im` = `obuf[rd_idx]`; `out_idx`=`rd_idx`.
  - `out_last`=`out_valid && rd_idx==N-1`.
  - On `out_valid&&out_ready`, `rd_idx` increments.
  - The handshake at `rd_idx`=N-1 clears `obuf_full`, wraps `rd_idx` to 0 and increments `frames_out`.
- **Data path:** pure transport. No arithmetic or scaling; values pass bit-exact.
- **abort** (priority over all other events in the same cycle):
  - Next state `S_LOAD`; `wr_idx`=`rd_idx`=0; `obuf_full`=0.
  - A sample or output handshake in the abort cycle is discarded.
  - `frames_out` and buffer contents are unchanged.
- **Reset values:** state `S_LOAD`; `in_ready`=1; `fft_start`=0; `out_valid`=0; `out_last`=0; `out_idx`=0; `frames_out`=0; `fft_in_*`, `out_re`, `out_im` = 0.

## Timing
- Single-frame latency, with `in_valid` and `out_ready` held high:
  - 64th sample accepted at edge t.
  - `fft_start` high in cycle t+1.
  - `S_WAIT` spans cycles t+2 … t+1+`FFT_LATENCY`.
  - `S_XFER` in cycle t+2+L; the snapshot happens at that cycle's closing edge.
  - `out_valid` is high from cycle t+3+L, bin 0 first.
  - The last bin is in cycle t+3+L+N-1.
- **Overlap:** loading of frame k+1 starts in cycle t+3+L, concurrently with the drain of frame k.
- **Same-cycle drain and snapshot:** if the final output handshake and `S_XFER` coincide, `obuf_full` is still 1 in that cycle. The snapshot happens one cycle later, so `out_valid` has a one-cycle bubble between frames.
- **Async reset:** reset asserted in any state clears every register immediately. `fft_start` drops combinationally-from-register with the reset; no pulse is issued after reset release.
- **Throughput:** at most one input sample and one output bin per cycle.

## Structure
- Shared package `fft_pkg`:
  - `fft_n`=64 and `fft_w`=16 constants.
  - `cplx_t` struct {re,im} of `W` bits each.
  - `ctrl_state_t` enum {S_LOAD,S_FIRE,S_WAIT,S_XFER}.
- Sub-module: `fft_obuf`, the N-entry snapshot buffer containing `rd_idx`, `obuf_full` and the output handshake.
- The FSM, `wr_idx`, the latency counter and the `fft_in_*` registers stay in the top level.

## Test plan
The bench drives `fft_out_*` from a stub that copies `fft_in_*` after `FFT_LATENCY` cycles.
- **Reset:** hold `rst`=0 → `in_ready`=1, `out_valid`=0, `fft_start`=0, `frames_out`=0.
- **Ramp frame:** `in_re`=i, `in_im`=-i for i=0..63, with `in_valid` and `out_ready` always high.
  - Exactly one `fft_start`, one cycle after the 64th accept.
  - Bin 0 appears L+2 cycles after `fft_start`; bin i has re=i, im=-i.
  - `out_last` asserts only at `out_idx`=63; `frames_out`=1.
- **Backpressure:** `out_ready`=0 while frames 1 and 2 are loaded.
  - FSM parks in `S_XFER` with `in_ready`=0.
  - Frame-1 output words stay unchanged.
  - After release, the frame-2 data (value 0x0020 for bins 0–31, 0 for bins 32–63) follows after a one-cycle bubble; `frames_out`=2.
- **Gappy input:** random `in_valid` toggling with 50 % duty → `wr_idx` advances only on handshakes; the frame is still bit-exact.
- **Abort:** assert `abort` at sample 20, with `in_valid` high that cycle.
  - That sample is dropped and `wr_idx`=0.
  - The next 64 samples form the frame; no `fft_start` fires before that.
- **Mid-WAIT reset:** pull `rst` low midway through `S_WAIT` → all outputs take reset values immediately; no `fft_start` and no `out_valid` until a fresh 64-sample frame is loaded.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame sequencer and its output buffer.
package fft_pkg;

  localparam int fft_n = 64;
  localparam int fft_w = 16;

  typedef struct packed {
    logic [fft_w-1:0] re;
    logic [fft_w-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_XFER = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/fft_obuf.sv
// N-entry snapshot of the FFT core results, streamed out one bin per handshake.
module fft_obuf
  import fft_pkg::*;
#(
  parameter int N = fft_n,
  parameter int W = fft_w,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            snap,
  input  logic [N*W-1:0]  fft_out_re,
  input  logic [N*W-1:0]  fft_out_im,
  input  logic            out_ready,
  output logic            full,
  output logic            out_valid,
  output logic [W-1:0]    out_re,
  output logic [W-1:0]    out_im,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic [15:0]     frames_out
);

  logic [W-1:0]  re_r [N];
  logic [W-1:0]  im_r [N];
  logic          full_r;
  logic [IW-1:0] rd_idx_r;
  logic [15:0]   frames_r;

  // Snapshot on request, advance the read pointer on each output handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_r   <= 1'b0;
      rd_idx_r <= '0;
      frames_r <= 16'd0;
      for (int i = 0; i < N; i++) begin
        re_r[i] <= '0;
        im_r[i] <= '0;
      end
    end else if (abort) begin
      full_r   <= 1'b0;
      rd_idx_r <= '0;
    end else if (snap) begin
      full_r <= 1'b1;
      for (int i = 0; i < N; i++) begin
        re_r[i] <= fft_out_re[i*W +: W];
        im_r[i] <= fft_out_im[i*W +: W];
      end
    end else if (full_r && out_ready) begin
      if (rd_idx_r == IW'(N-1)) begin
        rd_idx_r <= '0;
        full_r   <= 1'b0;
        frames_r <= frames_r + 16'd1;
      end else begin
        rd_idx_r <= rd_idx_r + IW'(1);
      end
    end
  end

  assign full       = full_r;
  assign out_valid  = full_r;
  assign out_re     = re_r[rd_idx_r];
  assign out_im     = im_r[rd_idx_r];
  assign out_idx    = rd_idx_r;
  assign out_last   = full_r && (rd_idx_r == IW'(N-1));
  assign frames_out = frames_r;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: assembles N samples for the FFT core, fires it, waits out its
// latency and hands the results to the output snapshot buffer.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N           = fft_n,
  parameter int W           = fft_w,
  parameter int FFT_LATENCY = 160
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_re,
  input  logic [W-1:0]           in_im,
  output logic [N*W-1:0]         fft_in_re,
  output logic [N*W-1:0]         fft_in_im,
  output logic                   fft_start,
  input  logic [N*W-1:0]         fft_out_re,
  input  logic [N*W-1:0]         fft_out_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_re,
  output logic [W-1:0]           out_im,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   out_last,
  output logic [15:0]            frames_out
);

  localparam int IW = $clog2(N);
  localparam int LW = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;

  ctrl_state_t   state_r, state_s;
  logic [IW-1:0] wr_idx_r;
  logic [LW-1:0] lat_cnt_r;
  logic [W-1:0]  in_re_r [N];
  logic [W-1:0]  in_im_r [N];
  logic          in_ready_s, fft_start_s, snap_s, accept_s, obuf_full_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = S_LOAD;
    end else begin
      case (state_r)
        S_LOAD: if (accept_s && wr_idx_r == IW'(N-1)) state_s = S_FIRE; else state_s = S_LOAD;
        S_FIRE: state_s = S_WAIT;
        S_WAIT: if (lat_cnt_r == '0) state_s = S_XFER; else state_s = S_WAIT;
        S_XFER: if (!obuf_full_s) state_s = S_LOAD; else state_s = S_XFER;
        default: state_s = S_LOAD;
      endcase
    end
  end

  // State decode; the snapshot waits while the previous frame is still draining
  always_comb begin
    in_ready_s  = 1'b0;
    fft_start_s = 1'b0;
    snap_s      = 1'b0;
    case (state_r)
      S_LOAD:  in_ready_s  = 1'b1;
      S_FIRE:  fft_start_s = 1'b1;
      S_WAIT:  in_ready_s  = 1'b0;
      S_XFER:  snap_s      = !obuf_full_s;
      default: in_ready_s  = 1'b0;
    endcase
  end

  assign accept_s = in_valid && in_ready_s && !abort;

  // Frame write pointer, sample registers and latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_r  <= '0;
      lat_cnt_r <= '0;
      for (int i = 0; i < N; i++) begin
        in_re_r[i] <= '0;
        in_im_r[i] <= '0;
      end
    end else if (abort) begin
      wr_idx_r <= '0;
    end else begin
      if (accept_s) begin
        in_re_r[wr_idx_r] <= in_re;
        in_im_r[wr_idx_r] <= in_im;
        wr_idx_r          <= wr_idx_r + IW'(1);
      end
      if (state_r == S_FIRE) begin
        lat_cnt_r <= LW'(FFT_LATENCY - 1);
      end else if (state_r == S_WAIT && lat_cnt_r != '0) begin
        lat_cnt_r <= lat_cnt_r - LW'(1);
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign fft_in_re[g*W +: W] = in_re_r[g];
    assign fft_in_im[g*W +: W] = in_im_r[g];
  end

  assign in_ready  = in_ready_s;
  assign fft_start = fft_start_s;

  fft_obuf #(.N(N), .W(W)) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .snap       (snap_s),
    .fft_out_re (fft_out_re),
    .fft_out_im (fft_out_im),
    .out_ready  (out_ready),
    .full       (obuf_full_s),
    .out_valid  (out_valid),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .frames_out (frames_out)
  );

endmodule
